// File: rtl/dec_onehot_scan.sv
// Binary-to-one-hot decoder with a direct valid/ready mode and a self-timed scan mode.
// Define DEC_ACTIVE_LOW_EN to drive y active-low (active bit 0, blank all ones).
module dec_onehot_scan #(
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [(1<<SEL_W)-1:0] y,
  output logic                  y_valid,
  output logic [SEL_W-1:0]      idx,
  output logic                  wrap
);
  localparam int N = 1 << SEL_W;

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  state_t             state;
  logic [DWELL_W-1:0] cnt;
  logic [SEL_W-1:0]   idx_inc;

  // Output polarity is applied once here so every y assignment stays active-high in intent.
  function automatic logic [N-1:0] drive(input logic [N-1:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  function automatic logic [N-1:0] onehot(input logic [SEL_W-1:0] s);
    return N'(1) << s;
  endfunction

  localparam logic [N-1:0] BLANK = drive('0);

  assign in_ready = en & ~mode & (state != SCAN);
  assign idx_inc  = idx + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= IDLE;
      y       <= BLANK;
      y_valid <= 1'b0;
      idx     <= '0;
      cnt     <= '0;
      wrap    <= 1'b0;
    end else if (!en) begin
      // Blank outputs; state, idx and cnt hold so the position resumes later.
      y       <= BLANK;
      y_valid <= 1'b0;
      wrap    <= 1'b0;
    end else if (mode) begin
      y_valid <= 1'b1;
      if (state != SCAN) begin
        state <= SCAN;
        idx   <= '0;
        cnt   <= '0;
        y     <= drive(onehot('0));
        wrap  <= 1'b0;
      end else if (cnt >= dwell) begin
        // dwell is live: lowering it below cnt forces an advance here.
        cnt  <= '0;
        idx  <= idx_inc;
        y    <= drive(onehot(idx_inc));
        wrap <= (idx == {SEL_W{1'b1}});
      end else begin
        cnt  <= cnt + 1'b1;
        y    <= drive(onehot(idx));
        wrap <= 1'b0;
      end
    end else begin
      wrap <= 1'b0;
      if (state == SCAN) begin
        state   <= IDLE;
        y       <= BLANK;
        y_valid <= 1'b0;
      end else if (in_valid) begin
        state   <= DIRECT;
        idx     <= sel;
        y       <= drive(onehot(sel));
        y_valid <= 1'b1;
      end else if (state == DIRECT) begin
        y       <= drive(onehot(idx));
        y_valid <= 1'b1;
      end else begin
        y       <= BLANK;
        y_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dec_onehot_scan.sv
// Directed bench for dec_onehot_scan (SEL_W=2, DWELL_W=8); expectations are hand-derived.
module tb_dec_onehot_scan;
  logic       clk = 1'b0;
  logic       rst_n, en, mode, in_valid, in_ready;
  logic [1:0] sel, idx;
  logic [7:0] dwell;
  logic [3:0] y;
  logic       y_valid, wrap;

  int checks = 0;
  int passed = 0;

  dec_onehot_scan #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .mode(mode), .in_valid(in_valid),
    .in_ready(in_ready), .sel(sel), .dwell(dwell), .y(y), .y_valid(y_valid),
    .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ey(input logic [3:0] v);
`ifdef DEC_ACTIVE_LOW_EN
    return ~v;
`else
    return v;
`endif
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; mode = 1'b0; in_valid = 1'b0; sel = 2'd0; dwell = 8'd0;
    cycle(); cycle();
    rst_n = 1'b1;

    // reset mid-scan
    mode = 1'b1; dwell = 8'd2;
    repeat (4) cycle();
    rst_n = 1'b0;
    cycle();
    chk("rst_y", y, ey(4'b0000));
    chk("rst_vld", y_valid, 0);
    chk("rst_idx", idx, 0);
    chk("rst_wrap", wrap, 0);
    mode = 1'b0;
    cycle();
    chk("rst2_y", y, ey(4'b0000));
    rst_n = 1'b1;

    // direct back-to-back
    in_valid = 1'b1; sel = 2'd3;
    chk("dir_rdy0", in_ready, 1);
    cycle();
    chk("dir_y3", y, ey(4'b1000)); chk("dir_idx3", idx, 3); chk("dir_vld", y_valid, 1);
    sel = 2'd0;
    chk("dir_rdy1", in_ready, 1);
    cycle();
    chk("dir_y0", y, ey(4'b0001)); chk("dir_idx0", idx, 0);
    sel = 2'd2;
    chk("dir_rdy2", in_ready, 1);
    cycle();
    chk("dir_y2", y, ey(4'b0100)); chk("dir_idx2", idx, 2);
    in_valid = 1'b0;
    cycle();
    chk("dir_hold", y, ey(4'b0100));

    // scan dwell=2
    mode = 1'b1; dwell = 8'd2;
    for (int k = 0; k < 14; k++) begin
      cycle();
      chk("scan2_y", y, ey(4'b0001 << ((k / 3) % 4)));
      chk("scan2_wrap", wrap, (k == 12) ? 1 : 0);
      chk("scan2_rdy", in_ready, 0);
    end
    // now idx=0 cnt=1 after k=13; one more edge reaches cnt=2
    cycle();
    chk("scan2_last", y, ey(4'b0001));

    // dwell=0: advance every cycle (cnt=2 >= 0 forces immediate advance)
    dwell = 8'd0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("scan0_y", y, ey(4'b0001 << ((k + 1) % 4)));
      chk("scan0_wrap", wrap, ((k % 4) == 3) ? 1 : 0);
    end

    // dwell 5 -> 1 at cnt=3
    dwell = 8'd5;
    repeat (3) cycle();
    chk("dw5_hold", y, ey(4'b0001));
    chk("dw5_idx", idx, 0);
    dwell = 8'd1;
    cycle();
    chk("dw1_adv", y, ey(4'b0010));
    chk("dw1_idx", idx, 1);

    // reach idx=2 cnt=0, then freeze
    cycle(); cycle();
    chk("pre_gate", y, ey(4'b0100));
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle();
      chk("gate_y", y, ey(4'b0000));
      chk("gate_vld", y_valid, 0);
      chk("gate_rdy", in_ready, 0);
      chk("gate_idx", idx, 2);
    end
    en = 1'b1;
    cycle();
    chk("resume_y", y, ey(4'b0100));
    chk("resume_vld", y_valid, 1);
    cycle();
    chk("resume_adv", y, ey(4'b1000));

    // mode switch with a pending sel
    mode = 1'b0; in_valid = 1'b1; sel = 2'd1;
    chk("msw_rdy0", in_ready, 0);
    cycle();
    chk("msw_idle_y", y, ey(4'b0000));
    chk("msw_idle_vld", y_valid, 0);
    chk("msw_rdy1", in_ready, 1);
    cycle();
    chk("msw_y", y, ey(4'b0010));
    chk("msw_idx", idx, 1);

    // en gating in DIRECT restores the held value
    in_valid = 1'b0; en = 1'b0;
    cycle();
    chk("dgate_y", y, ey(4'b0000));
    en = 1'b1;
    cycle();
    chk("drest_y", y, ey(4'b0010));
    chk("drest_vld", y_valid, 1);

    // entering scan ignores pending sel
    mode = 1'b1; in_valid = 1'b1; sel = 2'd3;
    cycle();
    chk("enter_y", y, ey(4'b0001));
    chk("enter_idx", idx, 0);
    chk("enter_wrap", wrap, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/dec_onehot_scan.md
Name: dec_onehot_scan

Overview:
- Parametrised binary-to-one-hot decoder with registered outputs.
- Direct mode: decodes an SEL_W-bit select, accepted over a valid/ready handshake.
- Scan mode: steps through all 2^SEL_W outputs by itself, holding each for a programmable dwell time.
- Drives digit/row strobes for multiplexed displays and keypads, and one-hot chip selects elsewhere in the design.

Parameters:
- SEL_W, 2, select width; output width N = 2^SEL_W (legal 1..6).
- DWELL_W, 8, width of the dwell-count input and the internal dwell counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active low.
- en  input  1  global enable; 0 blanks the outputs and freezes all state.
- mode  input  1  0 = direct decode, 1 = auto scan.
- in_valid  input  1  sel is valid.
- in_ready  output  1  block accepts sel this cycle.
- sel  input  SEL_W  select to decode (direct mode).
- dwell  input  DWELL_W  cycles-minus-one each scan output is held.
- y  output  N  one-hot decoded output (registered).
- y_valid  output  1  y holds a decoded value.
- idx  output  SEL_W  binary index of the active bit of y.
- wrap  output  1  one-cycle pulse when the scan wraps from N-1 to 0.

Behaviour:
- All outputs are registered. in_ready is combinational from state, mode and en.
- Reset, with rst_n low at a clock edge:
  - state = IDLE
  - y = 0, y_valid = 0, idx = 0, wrap = 0
  - dwell counter cnt = 0
  - Applies from any state, including mid-scan.
- in_ready = en & ~mode & (state != SCAN).
- Handshake: a transfer occurs on a cycle with in_valid & in_ready.
  - Next cycle: y = 1 << sel, idx = sel, y_valid = 1, state = DIRECT.
  - Latency is 1 cycle.
  - y holds until the next transfer; a back-to-back transfer every cycle is legal.
- States:
  - IDLE: y = 0, y_valid = 0.
    - To DIRECT on a transfer.
    - To SCAN when en & mode.
  - DIRECT: y holds the last decoded value.
    - Stays in DIRECT on a new transfer (y updates).
    - To SCAN when en & mode.
  - SCAN: y = 1 << idx, y_valid = 1.
    - To IDLE when en & ~mode; y and y_valid clear next cycle, and in_ready rises that same next cycle.
- Entering SCAN: the next cycle has idx = 0, y = onehot(0), cnt = 0. Any pending sel is ignored.
- Scan stepping, evaluated each cycle in SCAN with en = 1:
  - If cnt >= dwell: cnt = 0 and idx = idx + 1, wrapping N-1 to 0. wrap = 1 in the same cycle y becomes onehot(0).
  - Otherwise: cnt = cnt + 1.
  - Each output is held dwell+1 cycles. dwell = 0 advances every cycle.
  - dwell is sampled live. Lowering it below cnt forces an advance at the next edge.
- en = 0, any state:
  - y and y_valid are driven 0 at the next edge; in_ready = 0.
  - state, idx and cnt freeze.
  - On en returning to 1, y restores from the frozen state/idx the following cycle: onehot(idx) if DIRECT or SCAN, 0 if IDLE.
- mode is sampled every cycle. Toggling it mid-dwell abandons the scan position.
- wrap = 0 in all other cycles and in all non-SCAN states.
- The SEL_W = 1 special case needs no extra logic: N = 2 and idx toggles.

Optional Feature:
- Macro: DEC_ACTIVE_LOW_EN.
- When defined:
  - y is inverted at the output register, for common-anode displays and active-low selects.
  - Active bit = 0, blank = all ones.
  - Reset value of y = all ones.
  - Blank states (IDLE, en = 0) drive all ones.
  - y_valid, idx, wrap and in_ready are unchanged.
- When undefined: active-high y as described above.

Test Plan (SEL_W = 2, DWELL_W = 8):
- Reset: hold rst_n = 0 for 2 cycles mid-scan -> y = 4'b0000, y_valid = 0, idx = 0, wrap = 0 after the first edge.
- Direct: mode = 0, en = 1, in_valid = 1 with sel = 3, 0, 2 on consecutive cycles -> in_ready = 1 throughout; y = 1000, 0001, 0100 one cycle after each; idx = 3, 0, 2.
- Scan: mode = 1, dwell = 2 -> y sequence 0001×3, 0010×3, 0100×3, 1000×3, 0001; wrap = 1 only on the first 0001 after 1000; in_ready = 0 throughout.
- Scan with dwell = 0 -> y changes every cycle; wrap pulses every 4 cycles. Change dwell from 5 to 1 while cnt = 3 -> advance at the next edge.
- Enable gating: en = 0 for 5 cycles while idx = 2 in SCAN -> y = 0000, y_valid = 0. On en = 1, y = 0100 resumes with cnt unchanged.
- Mode switch: mode 1 -> 0 with in_valid = 1, sel = 1 in the same cycle -> no transfer; next cycle IDLE (y = 0000), in_ready = 1, transfer; y = 0010 a cycle later. With DEC_ACTIVE_LOW_EN, the same run gives y = 1111 then 1101.
